instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Packs structured instruction fields into 32-bit ARM-subset words for instruction memory.
- Covers data-processing, load/store and branch formats, with bit positions identical to those the control_unit decodes.
- Sits between the test/program-loader front end and the instruction-memory write port. Valid/ready on both sides; registered single-word output stage; auto-incrementing word address.

Parameters:
- ADDR_W, 8, instruction-memory byte-address width; the address counter wraps modulo 2^ADDR_W.
- ADDR_STEP, 4, byte increment per emitted word.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  field tuple valid
- in_ready  out  1  encoder accepts the tuple this cycle
- enc_type  in  2  00 data-proc, 01 load/store, 10 branch, 11 illegal
- cond  in  4  condition field
- opcode  in  4  data-processing opcode
- imm_flag  in  1  I bit
- s_bit  in  1  S bit (data-processing)
- ls_load  in  1  L bit: 1 load, 0 store
- ls_byte  in  1  B bit
- ls_up  in  1  U bit
- br_link  in  1  branch L bit
- rn  in  4  base/first operand register
- rd  in  4  destination register
- operand2  in  12  shifter operand or load/store offset
- br_offset  in  24  branch word offset
- out_valid  out  1  instr_word/mem_addr valid
- out_ready  in  1  memory accepts the word
- instr_word  out  32  encoded word
- mem_addr  out  ADDR_W  byte address for instr_word
- enc_err  out  1  sticky: illegal type seen, or a non-NOP tuple encoded to all zeros

Behaviour:
- Reset (async, rst_n low): out_valid=0, instr_word=0, mem_addr=0, enc_err=0, FSM to IDLE. Reset mid-transfer drops the held word; there is no replay.
- Encodings:
  - Data-proc: [31:28]=cond, [27:26]=00, [25]=imm_flag, [24:21]=opcode, [20]=s_bit, [19:16]=rn, [15:12]=rd, [11:0]=operand2.
  - Load/store: [27:26]=01, [25]=imm_flag, [24]=1 (P), [23]=ls_up, [22]=ls_byte, [21]=0 (W), [20]=ls_load, then rn, rd, operand2.
  - Branch: [27:25]=101, [24]=br_link, [23:0]=br_offset.
  - Illegal type (11): emits 32'h0 (NOP) and sets enc_err.
- All-zero hazard: a legal data-proc tuple that encodes to 32'h0 is emitted unchanged and sets enc_err, because the decoder will treat that word as a NOP.
- Latency: 1 cycle from the accept edge to out_valid.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Fully throughput-capable: one word per cycle when out_ready is held high.
- Transfer occurs on out_valid && out_ready. On a transfer, mem_addr += ADDR_STEP, wrapping 2^ADDR_W-4 -> 0 silently.
- instr_word and mem_addr are held stable while out_valid && !out_ready.
- Simultaneous transfer and accept in one cycle: the new word loads, out_valid stays 1, mem_addr advances.
- FSM states: IDLE (normal), PAD (see optional feature). Without the feature, the FSM is permanently IDLE.
- enc_err clears only on reset.

Optional Feature:
- Macro: INSTR_ENCODER_BRANCH_PAD_EN.
- Enabled: after a branch word transfers, the FSM enters PAD, forces in_ready=0 and emits one NOP word (32'h0) at the next address. It returns to IDLE on that NOP's transfer; the NOP obeys the same out_ready stall rules.
- Disabled: no padding; PAD logic is absent.

Decomposition:
- Package instr_encoder_pkg: enc_type localparams (ENC_DP, ENC_LS, ENC_BR, ENC_ILL), field bit-position constants shared with control_unit, NOP word constant, FSM state typedef.
- Sub-module: instr_field_pack, purely combinational tuple -> 32-bit word plus illegal and all-zero flags.
- The top level holds the output register, handshake, address counter and FSM.

Test Plan:
- DP ADD: cond=E, opcode=0100, I=1, S=1, rn=1, rd=2, op2=0x005, out_ready=1 -> next cycle instr_word=32'hE2912005, mem_addr=0; the following word appears at mem_addr=4.
- LS: LDRB with cond=E, I=1, U=1, B=1, L=1, rn=3, rd=4, off=0x010 -> 32'hE7D34010. STR with B=0, L=0 -> 32'hE7834010.
- Backpressure: out_ready=0 for 5 cycles after the first word -> instr_word and mem_addr stable, in_ready=0; release -> transfer, then back-to-back words at 1 per cycle.
- Wrap and errors: ADDR_W=4, 5 transfers -> mem_addr sequence 0, 4, 8, C, 0. enc_type=11 -> word 0 and enc_err=1. rst_n low mid-stall -> all outputs 0 immediately (async).
- With INSTR_ENCODER_BRANCH_PAD_EN: branch cond=E, L=0, offset=0x000003 -> 32'hEA000003 at addr 0, then 32'h0 at addr 4 with in_ready=0, then the next tuple at addr 8. Without the macro, the next tuple lands at addr 4.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// ============================================================================
//  Module      : instr_encoder_pkg
//  Description : Shared encoding constants for the instruction encoder:
//                enc_type codes, instruction field bit positions (identical
//                to those the control_unit decodes), NOP word, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_encoder_pkg;

    // Tuple format selector
    localparam logic [1:0] ENC_DP  = 2'b00;
    localparam logic [1:0] ENC_LS  = 2'b01;
    localparam logic [1:0] ENC_BR  = 2'b10;
    localparam logic [1:0] ENC_ILL = 2'b11;

    // Field bit positions shared with the decoder
    localparam int COND_LSB     = 28;
    localparam int CLASS_LSB    = 26;
    localparam int IMM_BIT      = 25;
    localparam int OPC_LSB      = 21;
    localparam int S_BIT        = 20;
    localparam int P_BIT        = 24;
    localparam int U_BIT        = 23;
    localparam int B_BIT        = 22;
    localparam int W_BIT        = 21;
    localparam int L_BIT        = 20;
    localparam int RN_LSB       = 16;
    localparam int RD_LSB       = 12;
    localparam int OP2_LSB      = 0;
    localparam int BR_CLASS_LSB = 25;
    localparam int LINK_BIT     = 24;
    localparam int BOFF_LSB     = 0;

    // Class codes placed at CLASS_LSB / BR_CLASS_LSB
    localparam logic [1:0] CLASS_DP = 2'b00;
    localparam logic [1:0] CLASS_LS = 2'b01;
    localparam logic [2:0] CLASS_BR = 3'b101;

    // The decoder treats an all-zero word as a no-op
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PAD  = 1'b1
    } state_t;

endpackage : instr_encoder_pkg

`default_nettype wire

// File: rtl/instr_encoder_if.sv
// ============================================================================
//  Module      : instr_encoder_if
//  Description : Field-tuple input handshake and instruction-memory write
//                handshake of the instruction encoder. The slave modport is
//                the encoder's view; master is the surrounding environment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_encoder_if #(
    parameter int ADDR_W = 8
) ();
    // Tuple side
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        enc_type;
    logic [3:0]        cond;
    logic [3:0]        opcode;
    logic              imm_flag;
    logic              s_bit;
    logic              ls_load;
    logic              ls_byte;
    logic              ls_up;
    logic              br_link;
    logic [3:0]        rn;
    logic [3:0]        rd;
    logic [11:0]       operand2;
    logic [23:0]       br_offset;
    // Memory side
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       instr_word;
    logic [ADDR_W-1:0] mem_addr;
    logic              enc_err;

    modport slave (
        input  in_valid, enc_type, cond, opcode, imm_flag, s_bit, ls_load,
               ls_byte, ls_up, br_link, rn, rd, operand2, br_offset, out_ready,
        output in_ready, out_valid, instr_word, mem_addr, enc_err
    );

    modport master (
        output in_valid, enc_type, cond, opcode, imm_flag, s_bit, ls_load,
               ls_byte, ls_up, br_link, rn, rd, operand2, br_offset, out_ready,
        input  in_ready, out_valid, instr_word, mem_addr, enc_err
    );

endinterface : instr_encoder_if

`default_nettype wire

// File: rtl/instr_field_pack.sv
// ============================================================================
//  Module      : instr_field_pack
//  Description : Combinational packer: field tuple -> 32-bit instruction word,
//                plus flags for an illegal type and for a legal tuple whose
//                word is all zeros (indistinguishable from a NOP).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  logic [1:0]  enc_type_i,
    input  logic [3:0]  cond_i,
    input  logic [3:0]  opcode_i,
    input  logic        imm_flag_i,
    input  logic        s_bit_i,
    input  logic        ls_load_i,
    input  logic        ls_byte_i,
    input  logic        ls_up_i,
    input  logic        br_link_i,
    input  logic [3:0]  rn_i,
    input  logic [3:0]  rd_i,
    input  logic [11:0] operand2_i,
    input  logic [23:0] br_offset_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        zero_o
);

    // Place each field at its decoder bit position according to the format
    always_comb begin
        word_o    = NOP_WORD;
        illegal_o = 1'b0;
        word_o[COND_LSB +: 4] = cond_i;
        case (enc_type_i)
            ENC_DP: begin
                word_o[CLASS_LSB +: 2] = CLASS_DP;
                word_o[IMM_BIT]        = imm_flag_i;
                word_o[OPC_LSB +: 4]   = opcode_i;
                word_o[S_BIT]          = s_bit_i;
                word_o[RN_LSB +: 4]    = rn_i;
                word_o[RD_LSB +: 4]    = rd_i;
                word_o[OP2_LSB +: 12]  = operand2_i;
            end
            ENC_LS: begin
                word_o[CLASS_LSB +: 2] = CLASS_LS;
                word_o[IMM_BIT]        = imm_flag_i;
                word_o[P_BIT]          = 1'b1;   // pre-indexed
                word_o[U_BIT]          = ls_up_i;
                word_o[B_BIT]          = ls_byte_i;
                word_o[W_BIT]          = 1'b0;   // no write-back
                word_o[L_BIT]          = ls_load_i;
                word_o[RN_LSB +: 4]    = rn_i;
                word_o[RD_LSB +: 4]    = rd_i;
                word_o[OP2_LSB +: 12]  = operand2_i;
            end
            ENC_BR: begin
                word_o[BR_CLASS_LSB +: 3] = CLASS_BR;
                word_o[LINK_BIT]          = br_link_i;
                word_o[BOFF_LSB +: 24]    = br_offset_i;
            end
            default: begin
                word_o    = NOP_WORD;
                illegal_o = 1'b1;
            end
        endcase
        zero_o = !illegal_o && (word_o == NOP_WORD);
    end

endmodule : instr_field_pack

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
//  Module      : instr_encoder
//  Description : Packs instruction field tuples into 32-bit words and writes
//                them to instruction memory through a registered output stage
//                with an auto-incrementing byte address.
//                Optional macro INSTR_ENCODER_BRANCH_PAD_EN: emit one NOP
//                after every transferred branch word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int ADDR_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_encoder_if.slave   bus
);

    logic [31:0]       pack_word;
    logic              pack_ill;
    logic              pack_zero;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [31:0]       word_q,  word_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              err_q,   err_d;
    logic              ready;
    logic              xfer;
    logic              accept;
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
    logic              br_q, br_d;   // held word is a branch still to be padded
`endif

    instr_field_pack u_pack (
        .enc_type_i  (bus.enc_type),
        .cond_i      (bus.cond),
        .opcode_i    (bus.opcode),
        .imm_flag_i  (bus.imm_flag),
        .s_bit_i     (bus.s_bit),
        .ls_load_i   (bus.ls_load),
        .ls_byte_i   (bus.ls_byte),
        .ls_up_i     (bus.ls_up),
        .br_link_i   (bus.br_link),
        .rn_i        (bus.rn),
        .rd_i        (bus.rd),
        .operand2_i  (bus.operand2),
        .br_offset_i (bus.br_offset),
        .word_o      (pack_word),
        .illegal_o   (pack_ill),
        .zero_o      (pack_zero)
    );

    // Handshake, next word/address/error and FSM next state
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        word_d  = word_q;
        addr_d  = addr_q;
        err_d   = err_q;
        xfer    = valid_q && bus.out_ready;
        ready   = (state_q == ST_IDLE) && (!valid_q || bus.out_ready);
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
        br_d    = br_q;
        // The slot after a branch belongs to its NOP, so no tuple may be
        // taken in the cycle the branch leaves.
        ready   = ready && !(valid_q && br_q);
`endif
        accept  = bus.in_valid && ready;

        if (xfer) begin
            addr_d  = addr_q + ADDR_W'(ADDR_STEP);
            valid_d = 1'b0;
        end
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
        if (xfer && br_q) begin
            word_d  = NOP_WORD;
            valid_d = 1'b1;
            br_d    = 1'b0;
            state_d = ST_PAD;
        end else if (xfer && (state_q == ST_PAD)) begin
            state_d = ST_IDLE;
        end
`endif
        if (accept) begin
            word_d  = pack_word;
            valid_d = 1'b1;
            err_d   = err_q | pack_ill | pack_zero;
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
            br_d    = (bus.enc_type == ENC_BR);
`endif
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            word_q  <= NOP_WORD;
            addr_q  <= '0;
            err_q   <= 1'b0;
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
            br_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
            br_q    <= br_d;
`endif
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid_q;
    assign bus.instr_word = word_q;
    assign bus.mem_addr   = addr_q;
    assign bus.enc_err    = err_q;

endmodule : instr_encoder

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Directed self-checking bench for instr_encoder; a second
//                instance with ADDR_W=4 exercises address wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(8)) bus  ();
    instr_encoder_if #(.ADDR_W(4)) bus4 ();

    instr_encoder #(.ADDR_W(8), .ADDR_STEP(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    instr_encoder #(.ADDR_W(4), .ADDR_STEP(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fields();
        bus.in_valid = 0; bus.enc_type = 0; bus.cond = 0; bus.opcode = 0;
        bus.imm_flag = 0; bus.s_bit = 0; bus.ls_load = 0; bus.ls_byte = 0;
        bus.ls_up = 0; bus.br_link = 0; bus.rn = 0; bus.rd = 0;
        bus.operand2 = 0; bus.br_offset = 0; bus.out_ready = 1;
    endtask

    // ADD cond=E I=1 S=1 rn=1 rd=2 op2=5 -> E2912005
    task automatic drive_add();
        clear_fields();
        bus.in_valid = 1; bus.enc_type = 2'b00; bus.cond = 4'hE;
        bus.opcode = 4'b0100; bus.imm_flag = 1; bus.s_bit = 1;
        bus.rn = 4'd1; bus.rd = 4'd2; bus.operand2 = 12'h005;
    endtask

    // LS cond=E I=1 U=1 rn=3 rd=4 off=0x010
    task automatic drive_ls(input logic b, input logic l);
        clear_fields();
        bus.in_valid = 1; bus.enc_type = 2'b01; bus.cond = 4'hE;
        bus.imm_flag = 1; bus.ls_up = 1; bus.ls_byte = b; bus.ls_load = l;
        bus.rn = 4'd3; bus.rd = 4'd4; bus.operand2 = 12'h010;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_fields();
        bus.in_valid = 0;
        apply_reset();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.instr_word !== 32'h0) begin n_err++; $display("FAIL rst_word: got %h want 00000000", bus.instr_word); end
        n_vec++; if (bus.mem_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr: got %h want 00", bus.mem_addr); end
        n_vec++; if (bus.enc_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus.enc_err); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.in_ready); end
    endtask

    // ADD, LDRB, STR back to back at one word per cycle
    task automatic test_back_to_back();
        drive_add();
        step();
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", bus.out_valid); end
        n_vec++; if (bus.instr_word !== 32'hE2912005) begin n_err++; $display("FAIL add_word: got %h want e2912005", bus.instr_word); end
        n_vec++; if (bus.mem_addr !== 8'h00) begin n_err++; $display("FAIL add_addr: got %h want 00", bus.mem_addr); end
        drive_ls(1'b1, 1'b1);
        step();
        n_vec++; if (bus.instr_word !== 32'hE7D34010) begin n_err++; $display("FAIL ldrb_word: got %h want e7d34010", bus.instr_word); end
        n_vec++; if (bus.mem_addr !== 8'h04) begin n_err++; $display("FAIL ldrb_addr: got %h want 04", bus.mem_addr); end
        drive_ls(1'b0, 1'b0);
        step();
        n_vec++; if (bus.instr_word !== 32'hE7834010) begin n_err++; $display("FAIL str_word: got %h want e7834010", bus.instr_word); end
        n_vec++; if (bus.mem_addr !== 8'h08) begin n_err++; $display("FAIL str_addr: got %h want 08", bus.mem_addr); end
        bus.in_valid = 0;
        step();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.mem_addr !== 8'h0C) begin n_err++; $display("FAIL drain_addr: got %h want 0c", bus.mem_addr); end
    endtask

    task automatic test_backpressure();
        drive_add();
        bus.out_ready = 0;
        step();
        drive_ls(1'b1, 1'b1);
        bus.out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (bus.instr_word !== 32'hE2912005) begin n_err++; $display("FAIL stall_word[%0d]: got %h want e2912005", i, bus.instr_word); end
            n_vec++; if (bus.mem_addr !== 8'h0C) begin n_err++; $display("FAIL stall_addr[%0d]: got %h want 0c", i, bus.mem_addr); end
            n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 0", i, bus.in_ready); end
            step();
        end
        bus.out_ready = 1;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", bus.in_ready); end
        step();
        n_vec++; if (bus.instr_word !== 32'hE7D34010) begin n_err++; $display("FAIL release_word: got %h want e7d34010", bus.instr_word); end
        n_vec++; if (bus.mem_addr !== 8'h10) begin n_err++; $display("FAIL release_addr: got %h want 10", bus.mem_addr); end
        bus.in_valid = 0;
        step();
        n_vec++; if (bus.mem_addr !== 8'h14) begin n_err++; $display("FAIL post_release_addr: got %h want 14", bus.mem_addr); end
    endtask

    task automatic test_illegal();
        drive_add();
        bus.enc_type = 2'b11;
        step();
        n_vec++; if (bus.instr_word !== 32'h0) begin n_err++; $display("FAIL ill_word: got %h want 00000000", bus.instr_word); end
        n_vec++; if (bus.enc_err !== 1'b1) begin n_err++; $display("FAIL ill_err: got %b want 1", bus.enc_err); end
        bus.in_valid = 0;
        step();
        step();
        n_vec++; if (bus.enc_err !== 1'b1) begin n_err++; $display("FAIL ill_err_sticky: got %b want 1", bus.enc_err); end
    endtask

    // Reset asserted mid-stall must clear outputs without a clock edge
    task automatic test_async_reset();
        drive_add();
        bus.out_ready = 0;
        step();
        bus.in_valid = 0;
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL pre_arst_valid: got %b want 1", bus.out_valid); end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.instr_word !== 32'h0) begin n_err++; $display("FAIL arst_word: got %h want 00000000", bus.instr_word); end
        n_vec++; if (bus.mem_addr !== 8'h00) begin n_err++; $display("FAIL arst_addr: got %h want 00", bus.mem_addr); end
        n_vec++; if (bus.enc_err !== 1'b0) begin n_err++; $display("FAIL arst_err: got %b want 0", bus.enc_err); end
        bus.out_ready = 1;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_zero_hazard();
        clear_fields();
        bus.in_valid = 1;
        step();
        bus.in_valid = 0;
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL zero_valid: got %b want 1", bus.out_valid); end
        n_vec++; if (bus.instr_word !== 32'h0) begin n_err++; $display("FAIL zero_word: got %h want 00000000", bus.instr_word); end
        n_vec++; if (bus.enc_err !== 1'b1) begin n_err++; $display("FAIL zero_err: got %b want 1", bus.enc_err); end
        step();
    endtask

    task automatic test_branch();
        clear_fields();
        apply_reset();
        bus.in_valid = 1; bus.enc_type = 2'b10; bus.cond = 4'hE;
        bus.br_link = 0; bus.br_offset = 24'h000003;
        step();
        n_vec++; if (bus.instr_word !== 32'hEA000003) begin n_err++; $display("FAIL br_word: got %h want ea000003", bus.instr_word); end
        n_vec++; if (bus.mem_addr !== 8'h00) begin n_err++; $display("FAIL br_addr: got %h want 00", bus.mem_addr); end
        drive_add();
        step();
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
        n_vec++; if (bus.instr_word !== 32'h0) begin n_err++; $display("FAIL pad_word: got %h want 00000000", bus.instr_word); end
        n_vec++; if (bus.mem_addr !== 8'h04) begin n_err++; $display("FAIL pad_addr: got %h want 04", bus.mem_addr); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL pad_ready: got %b want 0", bus.in_ready); end
        bus.out_ready = 0;
        step();
        n_vec++; if ({bus.out_valid, bus.instr_word, bus.mem_addr} !== {1'b1, 32'h0, 8'h04}) begin n_err++; $display("FAIL pad_stall: got %b/%h/%h want 1/00000000/04", bus.out_valid, bus.instr_word, bus.mem_addr); end
        bus.out_ready = 1;
        step();
        step();
        n_vec++; if (bus.instr_word !== 32'hE2912005) begin n_err++; $display("FAIL after_pad_word: got %h want e2912005", bus.instr_word); end
        n_vec++; if (bus.mem_addr !== 8'h08) begin n_err++; $display("FAIL after_pad_addr: got %h want 08", bus.mem_addr); end
`else
        n_vec++; if (bus.instr_word !== 32'hE2912005) begin n_err++; $display("FAIL after_br_word: got %h want e2912005", bus.instr_word); end
        n_vec++; if (bus.mem_addr !== 8'h04) begin n_err++; $display("FAIL after_br_addr: got %h want 04", bus.mem_addr); end
`endif
        bus.in_valid = 0;
        step();
    endtask

    task automatic test_wrap();
        apply_reset();
        bus4.in_valid = 1; bus4.enc_type = 2'b00; bus4.cond = 4'hE;
        bus4.opcode = 4'b0100; bus4.rd = 4'd2; bus4.out_ready = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            logic [3:0] exp_addr;
            exp_addr = 4'(i * 4);
            n_vec++; if (bus4.mem_addr !== exp_addr) begin n_err++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, bus4.mem_addr, exp_addr); end
            step();
        end
        bus4.in_valid = 0;
    endtask

    initial begin
        bus4.in_valid = 0; bus4.enc_type = 0; bus4.cond = 0; bus4.opcode = 0;
        bus4.imm_flag = 0; bus4.s_bit = 0; bus4.ls_load = 0; bus4.ls_byte = 0;
        bus4.ls_up = 0; bus4.br_link = 0; bus4.rn = 0; bus4.rd = 0;
        bus4.operand2 = 0; bus4.br_offset = 0; bus4.out_ready = 1;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_async_reset();
        test_zero_hazard();
        test_branch();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_instr_encoder

`default_nettype wire
